// File: rtl/fwd_hazard_ctrl.sv
// Forwarding select and load-use stall controller for the RV32 five-stage pipeline.
// Optional stall counter output is enabled by defining FWD_STALL_CNT_EN.
module fwd_hazard_ctrl #(
  parameter int addr_width = 5,
  parameter int cnt_width  = 32
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  id_valid_in,
  input  logic [addr_width-1:0] id_rs1_in,
  input  logic [addr_width-1:0] id_rs2_in,
  input  logic                  id_use_rs1_in,
  input  logic                  id_use_rs2_in,
  input  logic [addr_width-1:0] id_rd_in,
  input  logic                  id_reg_wen_in,
  input  logic                  id_load_in,
  input  logic                  flush_in,
  output logic [1:0]            fwd_a_sel_out,
  output logic [1:0]            fwd_b_sel_out,
  output logic                  stall_out,
  output logic                  ex_valid_out
`ifdef FWD_STALL_CNT_EN
  ,
  output logic [cnt_width-1:0]  stall_cnt_out
`endif
);

  typedef struct packed {
    logic                  valid;
    logic [addr_width-1:0] rs1;
    logic [addr_width-1:0] rs2;
    logic                  use1;
    logic                  use2;
    logic [addr_width-1:0] rd;
    logic                  wen;
    logic                  load;
  } ex_slot_t;

  // Only the producer fields matter once an instruction has left EX.
  typedef struct packed {
    logic                  valid;
    logic [addr_width-1:0] rd;
    logic                  wen;
  } prod_slot_t;

  ex_slot_t   ex_q, ex_d;
  prod_slot_t mem_q, wb_q;
  logic       hazard;

  function automatic logic prod_hit(input prod_slot_t p, input logic [addr_width-1:0] rs);
    return p.valid & p.wen & (p.rd != '0) & (p.rd == rs);
  endfunction

  assign hazard = id_valid_in & ex_q.valid & ex_q.load & ex_q.wen & (ex_q.rd != '0) &
                  ((id_use_rs1_in & (id_rs1_in == ex_q.rd)) |
                   (id_use_rs2_in & (id_rs2_in == ex_q.rd)));

  // A flushed consumer is killed anyway, so it must not hold the front end.
  assign stall_out    = hazard & ~flush_in;
  assign ex_valid_out = ex_q.valid;

  always_comb begin
    ex_d.valid = id_valid_in & ~flush_in & ~stall_out;
    ex_d.rs1   = id_rs1_in;
    ex_d.rs2   = id_rs2_in;
    ex_d.use1  = id_use_rs1_in;
    ex_d.use2  = id_use_rs2_in;
    ex_d.rd    = id_rd_in;
    ex_d.wen   = id_reg_wen_in;
    ex_d.load  = id_load_in;
  end

  // The younger producer in MEM takes priority over the one in WB.
  always_comb begin
    fwd_a_sel_out = 2'b00;
    fwd_b_sel_out = 2'b00;
    if (ex_q.valid && ex_q.use1) begin
      if (prod_hit(mem_q, ex_q.rs1))     fwd_a_sel_out = 2'b10;
      else if (prod_hit(wb_q, ex_q.rs1)) fwd_a_sel_out = 2'b11;
    end
    if (ex_q.valid && ex_q.use2) begin
      if (prod_hit(mem_q, ex_q.rs2))     fwd_b_sel_out = 2'b10;
      else if (prod_hit(wb_q, ex_q.rs2)) fwd_b_sel_out = 2'b11;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      ex_q.valid  <= 1'b0;
      mem_q.valid <= 1'b0;
      wb_q.valid  <= 1'b0;
    end else begin
      ex_q        <= ex_d;
      mem_q.valid <= ex_q.valid;
      mem_q.rd    <= ex_q.rd;
      mem_q.wen   <= ex_q.wen;
      wb_q        <= mem_q;
    end
  end

`ifdef FWD_STALL_CNT_EN
  logic [cnt_width-1:0] stall_cnt_q;

  always_ff @(posedge clk_in) begin
    if (rst_in)         stall_cnt_q <= '0;
    else if (stall_out) stall_cnt_q <= stall_cnt_q + cnt_width'(1);
  end

  assign stall_cnt_out = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Randomized and directed bench for fwd_hazard_ctrl against an instruction-history model.
// Define FWD_STALL_CNT_EN here too when the DUT is built with the stall counter.
module tb_fwd_hazard_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        id_valid_in;
  logic [4:0]  id_rs1_in;
  logic [4:0]  id_rs2_in;
  logic        id_use_rs1_in;
  logic        id_use_rs2_in;
  logic [4:0]  id_rd_in;
  logic        id_reg_wen_in;
  logic        id_load_in;
  logic        flush_in;
  logic [1:0]  fwd_a_sel_out;
  logic [1:0]  fwd_b_sel_out;
  logic        stall_out;
  logic        ex_valid_out;
`ifdef FWD_STALL_CNT_EN
  logic [31:0] stall_cnt_out;
`endif

  always #5 clk_in = ~clk_in;

  fwd_hazard_ctrl #(.addr_width(5), .cnt_width(32)) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .id_valid_in   (id_valid_in),
    .id_rs1_in     (id_rs1_in),
    .id_rs2_in     (id_rs2_in),
    .id_use_rs1_in (id_use_rs1_in),
    .id_use_rs2_in (id_use_rs2_in),
    .id_rd_in      (id_rd_in),
    .id_reg_wen_in (id_reg_wen_in),
    .id_load_in    (id_load_in),
    .flush_in      (flush_in),
    .fwd_a_sel_out (fwd_a_sel_out),
    .fwd_b_sel_out (fwd_b_sel_out),
    .stall_out     (stall_out),
    .ex_valid_out  (ex_valid_out)
`ifdef FWD_STALL_CNT_EN
    ,
    .stall_cnt_out (stall_cnt_out)
`endif
  );

  typedef struct {
    bit       valid;
    bit [4:0] rs1;
    bit [4:0] rs2;
    bit       use1;
    bit       use2;
    bit [4:0] rd;
    bit       wen;
    bit       load;
  } instr_t;

  // history[0] is the instruction in EX, [1] one cycle older, [2] two cycles older
  instr_t history[3];
  instr_t nop;
  int     checks;
  int     errors;
  int     stall_count;
  logic [1:0]  obs_a, obs_b;
  logic        obs_stall, obs_exv;
  logic [31:0] obs_cnt;

  function automatic instr_t mk(bit [4:0] rd, bit [4:0] rs1, bit [4:0] rs2,
                                bit use1, bit use2, bit wen, bit load);
    instr_t i;
    i.valid = 1'b1; i.rd = rd; i.rs1 = rs1; i.rs2 = rs2;
    i.use1 = use1; i.use2 = use2; i.wen = wen; i.load = load;
    return i;
  endfunction

  function automatic instr_t randInstr();
    instr_t i;
    i.valid = ($urandom_range(0, 9) != 0);
    i.rd    = 5'($urandom_range(0, 3));
    i.rs1   = 5'($urandom_range(0, 3));
    i.rs2   = 5'($urandom_range(0, 3));
    i.use1  = ($urandom_range(0, 3) != 0);
    i.use2  = ($urandom_range(0, 2) != 0);
    i.wen   = ($urandom_range(0, 4) != 0);
    i.load  = ($urandom_range(0, 3) == 0);
    return i;
  endfunction

  // Search the older instructions, youngest first, for one that writes rs.
  function automatic logic [1:0] expectSel(bit [4:0] rs, bit use_rs);
    if (!history[0].valid || !use_rs) return 2'b00;
    for (int d = 1; d <= 2; d++)
      if (history[d].valid && history[d].wen && history[d].rd != 0 && history[d].rd == rs)
        return (d == 1) ? 2'b10 : 2'b11;
    return 2'b00;
  endfunction

  function automatic bit expectStall(instr_t id, bit flush);
    instr_t p;
    p = history[0];
    if (flush || !id.valid) return 1'b0;
    if (!(p.valid && p.load && p.wen && p.rd != 0)) return 1'b0;
    return (id.use1 && id.rs1 == p.rd) || (id.use2 && id.rs2 == p.rd);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input instr_t id, input bit flush, input bit rst, output bit stalled);
    bit e_stall;
    @(negedge clk_in);
    rst_in        = rst;
    id_valid_in   = id.valid;
    id_rs1_in     = id.rs1;
    id_rs2_in     = id.rs2;
    id_use_rs1_in = id.use1;
    id_use_rs2_in = id.use2;
    id_rd_in      = id.rd;
    id_reg_wen_in = id.wen;
    id_load_in    = id.load;
    flush_in      = flush;
    #1;
    e_stall   = expectStall(id, flush);
    obs_a     = fwd_a_sel_out;
    obs_b     = fwd_b_sel_out;
    obs_stall = stall_out;
    obs_exv   = ex_valid_out;
    checkOutput("sel_a", 32'(fwd_a_sel_out), 32'(expectSel(history[0].rs1, history[0].use1)));
    checkOutput("sel_b", 32'(fwd_b_sel_out), 32'(expectSel(history[0].rs2, history[0].use2)));
    checkOutput("stall", 32'(stall_out), 32'(e_stall));
    checkOutput("ex_valid", 32'(ex_valid_out), 32'(history[0].valid));
    checkOutput("no_load_fwd", 32'((fwd_a_sel_out == 2'b10 || fwd_b_sel_out == 2'b10) &&
                                   history[1].valid && history[1].load), 32'd0);
`ifdef FWD_STALL_CNT_EN
    obs_cnt = stall_cnt_out;
    checkOutput("stall_cnt", stall_cnt_out, 32'(stall_count));
`else
    obs_cnt = 32'd0;
`endif
    @(posedge clk_in);
    if (rst) begin
      for (int k = 0; k < 3; k++) history[k] = nop;
      stall_count = 0;
    end else begin
      history[2] = history[1];
      history[1] = history[0];
      history[0] = (flush || e_stall || !id.valid) ? nop : id;
      if (e_stall) stall_count++;
    end
    stalled = e_stall;
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    instr_t cur;
    bit st;
    bit flush;
    checks = 0; errors = 0; stall_count = 0;
    nop = '{default: 0};
    for (int k = 0; k < 3; k++) history[k] = nop;
    rst_in = 1'b1; id_valid_in = 1'b0; id_rs1_in = '0; id_rs2_in = '0;
    id_use_rs1_in = 1'b0; id_use_rs2_in = 1'b0; id_rd_in = '0;
    id_reg_wen_in = 1'b0; id_load_in = 1'b0; flush_in = 1'b0;
    repeat (2) @(posedge clk_in);

    $display("[TB] reset state");
    applyStimulus(nop, 1'b0, 1'b0, st);
    checkOutput("rst_sel_a", 32'(obs_a), 32'd0);
    checkOutput("rst_sel_b", 32'(obs_b), 32'd0);
    checkOutput("rst_stall", 32'(obs_stall), 32'd0);
    checkOutput("rst_exv", 32'(obs_exv), 32'd0);

    $display("[TB] back-to-back ALU");
    applyStimulus(mk(5, 1, 2, 1, 1, 1, 0), 1'b0, 1'b0, st);
    applyStimulus(mk(6, 5, 5, 1, 1, 1, 0), 1'b0, 1'b0, st);
    checkOutput("b2b_nostall", 32'(obs_stall), 32'd0);
    applyStimulus(nop, 1'b0, 1'b0, st);
    checkOutput("b2b_sel_a", 32'(obs_a), 32'd2);
    checkOutput("b2b_sel_b", 32'(obs_b), 32'd2);

    $display("[TB] distance two");
    applyStimulus(mk(7, 1, 2, 1, 1, 1, 0), 1'b0, 1'b0, st);
    applyStimulus(mk(11, 3, 4, 1, 1, 1, 0), 1'b0, 1'b0, st);
    applyStimulus(mk(12, 3, 7, 1, 1, 1, 0), 1'b0, 1'b0, st);
    applyStimulus(nop, 1'b0, 1'b0, st);
    checkOutput("d2_sel_a", 32'(obs_a), 32'd0);
    checkOutput("d2_sel_b", 32'(obs_b), 32'd3);

    $display("[TB] double producer");
    applyStimulus(mk(8, 1, 2, 1, 1, 1, 0), 1'b0, 1'b0, st);
    applyStimulus(mk(8, 3, 4, 1, 1, 1, 0), 1'b0, 1'b0, st);
    applyStimulus(mk(13, 8, 8, 1, 0, 1, 0), 1'b0, 1'b0, st);
    applyStimulus(nop, 1'b0, 1'b0, st);
    checkOutput("dbl_sel_a", 32'(obs_a), 32'd2);
    checkOutput("dbl_sel_b", 32'(obs_b), 32'd0);

    $display("[TB] load-use");
    applyStimulus(mk(9, 1, 0, 1, 0, 1, 1), 1'b0, 1'b0, st);
    applyStimulus(mk(10, 9, 1, 1, 1, 1, 0), 1'b0, 1'b0, st);
    checkOutput("lu_stall", 32'(obs_stall), 32'd1);
`ifdef FWD_STALL_CNT_EN
    checkOutput("lu_cnt_before", obs_cnt, 32'd0);
`endif
    applyStimulus(mk(10, 9, 1, 1, 1, 1, 0), 1'b0, 1'b0, st);
    checkOutput("lu_stall_once", 32'(obs_stall), 32'd0);
    checkOutput("lu_bubble", 32'(obs_exv), 32'd0);
    applyStimulus(nop, 1'b0, 1'b0, st);
    checkOutput("lu_exv", 32'(obs_exv), 32'd1);
    checkOutput("lu_sel_a", 32'(obs_a), 32'd3);
`ifdef FWD_STALL_CNT_EN
    checkOutput("lu_cnt_after", obs_cnt, 32'd1);
`endif

    $display("[TB] x0 and flush");
    applyStimulus(mk(0, 1, 2, 1, 1, 1, 0), 1'b0, 1'b0, st);
    applyStimulus(mk(14, 0, 0, 1, 1, 1, 0), 1'b0, 1'b0, st);
    applyStimulus(nop, 1'b0, 1'b0, st);
    checkOutput("x0_sel_a", 32'(obs_a), 32'd0);
    checkOutput("x0_sel_b", 32'(obs_b), 32'd0);
    applyStimulus(mk(13, 1, 2, 1, 0, 1, 1), 1'b0, 1'b0, st);
    applyStimulus(mk(15, 13, 2, 1, 1, 1, 0), 1'b1, 1'b0, st);
    checkOutput("flush_nostall", 32'(obs_stall), 32'd0);
    applyStimulus(nop, 1'b0, 1'b0, st);
    checkOutput("flush_bubble", 32'(obs_exv), 32'd0);

    $display("[TB] reset mid-stream");
    applyStimulus(mk(14, 1, 2, 1, 1, 1, 0), 1'b0, 1'b0, st);
    applyStimulus(mk(15, 1, 2, 1, 1, 1, 0), 1'b0, 1'b0, st);
    applyStimulus(mk(16, 1, 2, 1, 1, 1, 0), 1'b0, 1'b0, st);
    applyStimulus(nop, 1'b0, 1'b1, st);
    applyStimulus(mk(17, 16, 15, 1, 1, 1, 0), 1'b0, 1'b0, st);
    checkOutput("mrst_exv", 32'(obs_exv), 32'd0);
    checkOutput("mrst_sel_a", 32'(obs_a), 32'd0);
`ifdef FWD_STALL_CNT_EN
    checkOutput("mrst_cnt", obs_cnt, 32'd0);
`endif
    applyStimulus(nop, 1'b0, 1'b0, st);
    checkOutput("mrst_drop_a", 32'(obs_a), 32'd0);
    checkOutput("mrst_drop_b", 32'(obs_b), 32'd0);

    $display("[TB] randomized traffic");
    cur = randInstr();
    for (int n = 0; n < 3000; n++) begin
      flush = ($urandom_range(0, 9) == 0);
      applyStimulus(cur, flush, ($urandom_range(0, 299) == 0), st);
      if (!st) cur = randInstr();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_ctrl.md
Name: fwd_hazard_ctrl

Overview:
- Forwarding and load-use hazard controller for the RV32 five-stage pipeline.
- Generates the 2-bit select codes consumed by the EX-stage operand 3-to-1 selectors: 00 = register file, 10 = EX/MEM result, 11 = MEM/WB result. Code 01 is never driven.
- Keeps its own shadow pipeline of destination-register and write/load flags for the EX, MEM and WB stages.
- Stalls the front end for one cycle on a load-use dependency.

Parameters:
- addr_width, 5, register address width (x0..x31).
- cnt_width, 32, width of the stall counter (optional feature only).

Ports:
- clk_in  input  1  clock, rising edge.
- rst_in  input  1  synchronous, active-high reset.
- id_valid_in  input  1  ID stage holds a real instruction.
- id_rs1_in  input  addr_width  ID source register 1.
- id_rs2_in  input  addr_width  ID source register 2.
- id_use_rs1_in  input  1  instruction reads rs1.
- id_use_rs2_in  input  1  instruction reads rs2.
- id_rd_in  input  addr_width  ID destination register.
- id_reg_wen_in  input  1  instruction writes rd.
- id_load_in  input  1  instruction is a load.
- flush_in  input  1  kill the instruction currently in ID (branch/jump taken).
- fwd_a_sel_out  output  2  operand A select for the instruction in EX.
- fwd_b_sel_out  output  2  operand B select for the instruction in EX.
- stall_out  output  1  hold PC and IF/ID; insert a bubble into EX.
- ex_valid_out  output  1  EX slot holds a real instruction.

Behaviour:
- State: three slots ex_, mem_, wb_. Each slot holds valid, rs1, rs2, use1, use2, rd, wen, load.
- Reset (rst_in=1 at edge): all slot valid bits cleared. Resulting outputs: fwd_a_sel_out=00, fwd_b_sel_out=00, stall_out=0, ex_valid_out=0. Reset mid-stream discards all in-flight entries.
- hazard (combinational) = id_valid_in & ex.valid & ex.load & ex.wen & ex.rd!=0 & ((id_use_rs1_in & id_rs1_in==ex.rd) | (id_use_rs2_in & id_rs2_in==ex.rd)).
- stall_out = hazard & ~flush_in. flush has priority, because the dependent instruction is killed.
- Each edge, when not in reset:
  - wb <= mem; mem <= ex, unconditionally.
  - ex <= bubble (valid=0) if flush_in | stall_out | ~id_valid_in; otherwise ex <= ID fields.
- A load-use stall lasts exactly 1 cycle: the bubble then sits in EX, so hazard cannot re-assert for the same pair.
- Operand select (combinational from slot registers only, no input-to-output path), evaluated for operand A (ex.rs1/use1) and likewise for B:
  - 10 if ex.valid & use & mem.valid & mem.wen & mem.rd!=0 & mem.rd==rs.
  - else 11 if ex.valid & use & wb.valid & wb.wen & wb.rd!=0 & wb.rd==rs.
  - else 00.
  - EX/MEM has priority over MEM/WB when both match (youngest producer wins).
  - x0 is never forwarded.
  - Outputs are 00 when the EX slot is a bubble.
- Invariant (bench assertion): a select of 10 is never driven when mem.load=1. The load-use stall guarantees this.
- ex_valid_out = ex.valid.
- The register file is write-first, so WB-to-ID needs no handling here.

Optional Feature:
- Macro FWD_STALL_CNT_EN.
- Defined: adds output port stall_cnt_out [cnt_width-1:0]. It is cleared by rst_in and increments by 1 on every edge where stall_out=1, wrapping to 0 after all-ones.
- Undefined: no port and no counter logic. All other behaviour is identical.

Test Plan:
- Back-to-back ALU: add x5 ← ..., then add x6,x5,x5 -> when the second is in EX, fwd_a_sel_out=10, fwd_b_sel_out=10, stall_out never 1.
- Distance 2: producer writes x7, one independent instruction, then a consumer reads x7 on rs2 -> fwd_b_sel_out=11, fwd_a_sel_out=00.
- Double producer: x8 written at distance 2 and distance 1, consumer reads x8 -> sel=10 (priority check).
- Load-use: lw x9 then add x10,x9,x1 -> stall_out=1 for exactly one cycle and ex_valid_out=0 the next cycle; the consumer then enters EX with fwd_a_sel_out=11. With FWD_STALL_CNT_EN, stall_cnt_out goes from 0 to 1.
- x0 / flush: producer writes x0 and consumer reads x0 -> sel=00. A load-use pair with flush_in=1 in the same cycle -> stall_out=0, and the ex slot becomes a bubble.
- Reset mid-stream: assert rst_in with three valid producers in flight -> next cycle all sel=00, ex_valid_out=0, and the counter is 0.
